// File: rtl/mult_iter_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mult_iter_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mult_iter_twoscomp.sv
// N-bit two's-complement negate.
module twoscomp_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = ~a + N'(1);
endmodule

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH+1 edges,
// signed or unsigned per operation, START/DONE handshake.
module mult_iter
  import mult_iter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mc, mp, acc_hi, acc_lo;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic               load, last;
  logic [WIDTH-1:0]   a_neg, b_neg, a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc, acc_neg, prod;

  twoscomp_n #(.N(WIDTH))   u_neg_a (.a(A),   .y(a_neg));
  twoscomp_n #(.N(WIDTH))   u_neg_b (.a(B),   .y(b_neg));
  twoscomp_n #(.N(2*WIDTH)) u_neg_p (.a(acc), .y(acc_neg));

  // |-2^(W-1)| wraps to 2^(W-1), which is exactly right as an unsigned magnitude
  assign a_mag = (SIGNED && A[WIDTH-1]) ? a_neg : A;
  assign b_mag = (SIGNED && B[WIDTH-1]) ? b_neg : B;
  assign acc   = {acc_hi, acc_lo};
  assign prod  = neg ? acc_neg : acc;
  assign sum   = {1'b0, acc_hi} + {1'b0, (mp[0] ? mc : '0)};

  assign load = START && (state == ST_IDLE || state == ST_DONE);
  assign last = (cnt == CW'(WIDTH - 1));
  assign BUSY = (state == ST_RUN) || (state == ST_FIX);
  assign DONE = (state == ST_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (START) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = START ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mc     <= '0;
      mp     <= '0;
      neg    <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      HI     <= '0;
      LO     <= '0;
    end else if (load) begin
      mc     <= a_mag;
      mp     <= b_mag;
      neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      // carry of the add shifts into acc_hi MSB; lowest sum bit moves into acc_lo
      acc_hi <= sum[WIDTH:1];
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      mp     <= mp >> 1;
      cnt    <= cnt + CW'(1);
    end else if (state == ST_FIX) begin
      HI <= prod[2*WIDTH-1:WIDTH];
      LO <= prod[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mult_iter.sv
// Directed + random scoreboard bench for mult_iter at WIDTH=32 and WIDTH=8.
module tb_mult_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st32, sg32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        st8, sg8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  mult_iter #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst), .START(st32), .SIGNED(sg32), .A(a32), .B(b32),
    .BUSY(busy32), .DONE(done32), .HI(hi32), .LO(lo32));

  mult_iter #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(st8), .SIGNED(sg8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .HI(hi8), .LO(lo8));

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  int t_load32, t_load8;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    st32 = 1'b1; sg32 = s; a32 = a; b32 = b;
    q32.push_back(exp);
    @(negedge clk);
    t_load32 = edge_cnt;
    // scramble operands after the load edge; they must not matter
    st32 = 1'b0; sg32 = ~s; a32 = $urandom; b32 = $urandom;
    chk("busy32_after_load", 64'(busy32), 64'd1);
  endtask

  task automatic finish32(input string tag);
    int k;
    logic [63:0] e;
    k = 0;
    do begin @(negedge clk); k++; end while (done32 !== 1'b1 && k < 200);
    chk({tag, "_latency"}, 64'(edge_cnt - t_load32), 64'd33);
    chk({tag, "_busy"}, 64'(busy32), 64'd0);
    e = q32.pop_front();
    chk({tag, "_hi"}, 64'(hi32), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo32), 64'(e[31:0]));
  endtask

  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, p;
    ia = s ? {{24{a[7]}}, a} : {24'd0, a};
    ib = s ? {{24{b[7]}}, b} : {24'd0, b};
    p  = ia * ib;
    q8.push_back(p[15:0]);
    st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    @(negedge clk);
    t_load8 = edge_cnt;
    st8 = 1'b0; sg8 = ~s; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic finish8();
    int k;
    logic [15:0] e;
    k = 0;
    do begin @(negedge clk); k++; end while (done8 !== 1'b1 && k < 50);
    chk("w8_latency", 64'(edge_cnt - t_load8), 64'd9);
    e = q8.pop_front();
    chk("w8_prod", 64'({hi8, lo8}), 64'(e));
  endtask

  initial begin
    int t1, t2;
    logic saw_done;
    logic [31:0] hold_hi, hold_lo;
    logic [7:0] ra, rb;
    logic rs;

    rst = 1'b1;
    st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_hilo32", 64'({hi32, lo32}), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_hilo8", 64'({hi8, lo8}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    start32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    finish32("umax");
    @(negedge clk);
    start32(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    finish32("sneg3x5");
    @(negedge clk);
    start32(1'b0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1);
    finish32("uneg3x5");
    @(negedge clk);
    start32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    finish32("smin_sq");
    @(negedge clk);
    start32(1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0);
    finish32("szero");

    // START pulse with other operands during RUN must be ignored
    @(negedge clk);
    start32(1'b0, 32'd1234, 32'd5678, 64'd1234 * 64'd5678);
    repeat (3) @(negedge clk);
    st32 = 1'b1; sg32 = 1'b1; a32 = 32'h1111_1111; b32 = 32'h2222_2222;
    @(negedge clk);
    st32 = 1'b0;
    finish32("ign_start");

    // back-to-back: START held through the DONE cycle
    @(negedge clk);
    start32(1'b1, 32'hFFFF_FF00, 32'd3, 64'hFFFF_FFFF_FFFF_FD00);
    finish32("b2b_first");
    t1 = edge_cnt;
    hold_hi = hi32; hold_lo = lo32;
    start32(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    repeat (5) @(negedge clk);
    chk("hold_during_run", 64'({hi32, lo32}), {32'hFFFF_FFFF, 32'hFFFF_FD00});
    t_load32 = t_load32;
    begin
      int k;
      logic [63:0] e;
      k = 0;
      do begin @(negedge clk); k++; end while (done32 !== 1'b1 && k < 200);
      t2 = edge_cnt;
      chk("b2b_spacing", 64'(t2 - t1), 64'd34);
      e = q32.pop_front();
      chk("b2b_second", 64'({hi32, lo32}), e);
    end
    chk("b2b_prev_hi_seen", 64'(hold_hi), 64'hFFFF_FFFF);

    // reset mid-RUN aborts with no DONE afterwards
    @(negedge clk);
    st32 = 1'b1; sg32 = 1'b0; a32 = 32'd7; b32 = 32'd9;
    @(negedge clk);
    st32 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy32), 64'd0);
    chk("abort_hilo", 64'({hi32, lo32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);

    // WIDTH=8: corners then random ops, issued back-to-back in the DONE cycle
    start8(1'b1, 8'h80, 8'h80); finish8();
    start8(1'b1, 8'h00, 8'hFF); finish8();
    start8(1'b0, 8'hFF, 8'hFF); finish8();
    for (int i = 0; i < 2000; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom); rb = 8'($urandom);
      start8(rs, ra, rb);
      finish8();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
